uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares a single UART transmitter among `NUM_REQ` byte-stream requesters. It sits between the requesting blocks (loopback buffer, status reporter, debug logger) and the `uart_tx` core inside `top_uart`. Each winning requester keeps the grant for one packet, ended by `req_last`, and one grant never covers more than `MAX_BURST` bytes. The arbiter issues one `tx_start` per byte and waits for the transmitter's busy/done cycle before issuing the next.

---
 rtl/uart_tx_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte-stream
// requesters. A grant lasts for one packet (ended by req_last), at most
// MAX_BURST bytes, or until the owner drops req_valid. Each byte gets one
// tx_start pulse, and the arbiter then waits for the transmitter's busy/done
// handshake. If tx_busy never rises, err_noack is set and the byte is treated
// as done.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16,
    parameter int BUSY_TO   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_busy,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       err_noack
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int BC_W = $clog2(MAX_BURST + 1);
    localparam int TO_W = $clog2(BUSY_TO + 1);

    typedef enum logic [1:0] {
        S_ARB,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ID_W-1:0]     r_rr_ptr;
    logic [BC_W-1:0]     r_burst_cnt;
    logic [TO_W-1:0]     r_to_cnt;
    logic                r_last_q;
    logic                r_tx_start;
    logic [7:0]          r_tx_data;
    logic                r_grant_valid;
    logic [ID_W-1:0]     r_grant_id;
    logic                r_err_noack;

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic                 w_hit;
    logic [ID_W:0]        w_sum;
    logic [ID_W-1:0]      w_winner;
    logic                 w_sel_valid;
    logic                 w_sel_last;
    logic [7:0]           w_sel_data;
    logic [NUM_REQ-1:0]   w_gnt_onehot;
    logic                 w_burst_full;
    logic                 w_grant;
    logic                 w_xfer;
    logic                 w_release;
    logic                 w_timeout;
    logic                 w_byte_done;

    // The request vector is rotated so that bit 0 is the requester at rr_ptr.
    // The first set bit is then the winner, translated back modulo NUM_REQ.
    assign w_dbl = {req_valid, req_valid} >> r_rr_ptr;
    assign w_rot = w_dbl[NUM_REQ-1:0];

    // Find the nearest valid requester at or after rr_ptr.
    always_comb begin
        w_hit    = 1'b0;
        w_sum    = '0;
        w_winner = '0;
        for (int unsigned i = NUM_REQ; i > 0; i--) begin
            if (w_rot[i-1]) begin
                w_hit = 1'b1;
                w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(i - 1);
            end
        end
        if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
            w_sum = w_sum - (ID_W+1)'(NUM_REQ);
        end
        w_winner = w_sum[ID_W-1:0];
    end

    // Select the request signals of the current owner.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == ID_W'(i)) begin
                w_sel_valid = req_valid[i];
                w_sel_last  = req_last[i];
                w_sel_data  = req_data[8*i +: 8];
            end
        end
    end

    assign w_gnt_onehot = NUM_REQ'(1) << r_grant_id;
    assign w_burst_full = (r_burst_cnt == BC_W'(MAX_BURST));

    // Only the owner's ready bit is driven, and only in ISSUE.
    always_comb begin
        req_ready = '0;
        if (r_state == S_ISSUE) begin
            req_ready = req_valid & w_gnt_onehot;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle control decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_xfer      = 1'b0;
        w_release   = 1'b0;
        w_timeout   = 1'b0;
        w_byte_done = 1'b0;
        case (r_state)
            S_ARB: begin
                if (w_hit) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_sel_valid) begin
                    w_xfer      = 1'b1;
                    w_state_nxt = S_WAIT_BUSY;
                end else begin
                    w_release   = 1'b1;
                    w_state_nxt = S_ARB;
                end
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_to_cnt == TO_W'(BUSY_TO - 1)) begin
                    w_timeout   = 1'b1;
                    w_byte_done = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_byte_done = 1'b1;
                end
            end
            default: w_state_nxt = S_ARB;
        endcase
        // A timed-out byte takes the same exit as a completed one.
        if (w_byte_done) begin
            if (r_last_q || w_burst_full) begin
                w_release   = 1'b1;
                w_state_nxt = S_ARB;
            end else begin
                w_state_nxt = S_ISSUE;
            end
        end
    end

    // Grant, byte, counter and error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr      <= '0;
            r_burst_cnt   <= '0;
            r_to_cnt      <= '0;
            r_last_q      <= 1'b0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= 8'h00;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_err_noack   <= 1'b0;
        end else begin
            r_tx_start <= w_xfer;
            if (w_grant) begin
                r_grant_id    <= w_winner;
                r_grant_valid <= 1'b1;
                r_burst_cnt   <= '0;
            end
            if (w_xfer) begin
                r_tx_data <= w_sel_data;
                r_last_q  <= w_sel_last;
                r_to_cnt  <= '0;
                if (!w_burst_full) begin
                    r_burst_cnt <= r_burst_cnt + 1'b1;
                end
            end else if (r_state == S_WAIT_BUSY && !tx_busy &&
                         r_to_cnt != TO_W'(BUSY_TO)) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_err_noack <= 1'b1;
            end
            if (w_release) begin
                r_grant_valid <= 1'b0;
                if (r_grant_id == ID_W'(NUM_REQ - 1)) begin
                    r_rr_ptr <= '0;
                end else begin
                    r_rr_ptr <= r_grant_id + 1'b1;
                end
            end
        end
    end

    assign tx_start    = r_tx_start;
    assign tx_data     = r_tx_data;
    assign grant_valid = r_grant_valid;
    assign grant_id    = r_grant_id;
    assign err_noack   = r_err_noack;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter. Requesters are byte queues; a
// packet-level model predicts which requester sends which byte from the
// round-robin rules, and a simple UART model produces the busy handshake.
module tb_uart_tx_arbiter;

    localparam int NR    = 4;
    localparam int MB    = 4;
    localparam int BTO   = 8;

    logic            clk;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR*8-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic            tx_start;
    logic [7:0]      tx_data;
    logic            tx_busy;
    logic            grant_valid;
    logic [1:0]      grant_id;
    logic            err_noack;

    uart_tx_arbiter #(
        .NUM_REQ   (NR),
        .MAX_BURST (MB),
        .BUSY_TO   (BTO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .err_noack   (err_noack)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc      = 0;
    int unsigned m_ptr    = 0;
    logic        exp_err  = 1'b0;
    logic        uart_en  = 1'b1;

    logic [8:0]  dq [NR][$];   // driver queues {last, data}
    logic [8:0]  mq [NR][$];   // model copy of the same queues
    logic [9:0]  exp_q [$];    // expected {requester, byte} per tx_start

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic load(input int unsigned r, input logic [7:0] d, input logic l);
        dq[r].push_back({l, d});
        mq[r].push_back({l, d});
    endtask

    // Packet-level rule: the first non-empty requester at/after the pointer
    // sends until its last byte, MAX_BURST bytes, or its queue runs dry; the
    // pointer then moves just past it.
    task automatic run_model();
        logic [8:0]  it;
        int unsigned w, n, j;
        bit          any, stop;
        while (1) begin
            any = 0;
            w   = 0;
            for (int unsigned k = 0; k < NR; k++) begin
                j = (m_ptr + k) % NR;
                if (!any && mq[j].size() > 0) begin
                    any = 1;
                    w   = j;
                end
            end
            if (!any) break;
            n    = 0;
            stop = 0;
            while (!stop) begin
                it = mq[w].pop_front();
                exp_q.push_back({2'(w), it[7:0]});
                n++;
                stop = it[8] || (n == MB) || (mq[w].size() == 0);
            end
            m_ptr = (w + 1) % NR;
        end
    endtask

    task automatic clear_all();
        for (int unsigned i = 0; i < NR; i++) begin
            dq[i].delete();
            mq[i].delete();
        end
        exp_q.delete();
    endtask

    task automatic wait_idle(input string tag);
        int unsigned n;
        bit          done;
        n    = 0;
        done = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
            done = (exp_q.size() == 0) && !grant_valid && !tx_busy;
            for (int unsigned i = 0; i < NR; i++) begin
                if (dq[i].size() != 0) done = 0;
            end
        end
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_err"}, 32'(err_noack), 32'(exp_err));
        if (!done) clear_all();
        repeat (3) @(negedge clk);
    endtask

    // Requester drivers: present queue heads, pop on accepted handshakes.
    initial begin
        logic [NR-1:0] hs;
        logic [8:0]    hd;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (hs[i] && dq[i].size() > 0) void'(dq[i].pop_front());
                if (dq[i].size() > 0) begin
                    hd = dq[i][0];
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = hd[7:0];
                    req_last[i]        = hd[8];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
        end
    end

    // UART transmitter model: busy rises shortly after tx_start, lasts a few
    // cycles, and the latched byte must still be on tx_data when it ends.
    initial begin
        logic [7:0] held;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start && uart_en) begin
                held = tx_data;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat ($urandom_range(2, 6)) @(posedge clk);
                #1 tx_busy = 1'b0;
                if (rst_n) check("tx_data_hold", 32'(tx_data), 32'(held));
            end
        end
    end

    // Every tx_start must match the next predicted byte and owner.
    initial forever begin
        logic [9:0] e;
        @(negedge clk);
        if (rst_n && tx_start) begin
            check("start_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("tx_data", 32'(tx_data), 32'(e[7:0]));
                check("grant_id", 32'(grant_id), 32'(e[9:8]));
                check("grant_valid_at_start", 32'(grant_valid), 1);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_start"}, 32'(tx_start), 0);
        check({tag, "_tx_data"}, 32'(tx_data), 0);
        check({tag, "_req_ready"}, 32'(req_ready), 0);
        check({tag, "_grant_valid"}, 32'(grant_valid), 0);
        check({tag, "_grant_id"}, 32'(grant_id), 0);
        check({tag, "_err_noack"}, 32'(err_noack), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_all();
        m_ptr   = 0;
        exp_err = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int unsigned n, s, npk, len;
        logic [3:0]  mask;
        bit          lst;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single packet from requester 0.
        load(0, 8'h55, 0); load(0, 8'hA3, 0); load(0, 8'h0F, 1);
        run_model();
        wait_idle("single");
        // Pointer now at 1: requester 1 beats requester 0.
        load(0, 8'h01, 1); load(1, 8'h02, 1);
        run_model();
        wait_idle("ptr_after_single");

        do_reset();
        // Contention right after reset, then 3 wins over a re-requesting 0.
        load(0, 8'h10, 1); load(1, 8'h20, 1); load(2, 8'h30, 1);
        run_model();
        wait_idle("contention");
        load(0, 8'h40, 1); load(3, 8'h33, 1);
        run_model();
        wait_idle("contention_rr");

        // Burst limit: six unterminated bytes from 1 while 2 waits.
        for (int b = 0; b < 6; b++) load(1, 8'(8'hB0 + b), 0);
        load(2, 8'hC0, 0); load(2, 8'hC1, 1);
        run_model();
        wait_idle("burst");

        // Valid drop mid-packet releases the grant to the next requester.
        load(0, 8'hD0, 0); load(1, 8'hD1, 1);
        run_model();
        wait_idle("valid_drop");

        for (int r = 0; r < 20; r++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < NR; i++) begin
                if (mask[i]) begin
                    npk = $urandom_range(1, 2);
                    for (int p = 0; p < int'(npk); p++) begin
                        len = $urandom_range(1, 5);
                        lst = ($urandom_range(0, 3) != 0);
                        for (int b = 0; b < int'(len); b++)
                            load(i, 8'($urandom), lst && (b == int'(len) - 1));
                    end
                end
            end
            run_model();
            wait_idle("rand");
        end

        // No acknowledge from the transmitter.
        uart_en = 1'b0;
        load(0, 8'hE1, 0); load(0, 8'hE2, 1);
        run_model();
        n = 0;
        while (!tx_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("noack_start_seen", 32'(tx_start), 1);
        s = cyc;
        n = 0;
        while (!err_noack && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("noack_latency", cyc - s, BTO);
        exp_err = 1'b1;
        wait_idle("noack");
        uart_en = 1'b1;
        load(1, 8'h77, 1);
        run_model();
        wait_idle("noack_sticky");

        // Reset while a byte is in the transmitter.
        load(2, 8'h91, 0); load(2, 8'h92, 1);
        run_model();
        n = 0;
        while (!(tx_busy && grant_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("midbyte_reached", 32'(tx_busy && grant_valid), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        clear_all();
        m_ptr   = 0;
        exp_err = 1'b0;
        n = 0;
        while (tx_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        load(0, 8'hA0, 1); load(3, 8'hA3, 1);
        run_model();
        wait_idle("post_reset");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
